// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: op encoding (matches funct3[1:0]), multiplier FSM states, timing constants.
package rv32m_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mul_state_e;

  localparam int MUL_ITER    = 32;
  localparam int MUL_LATENCY = 34;

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add RV32M multiplier: 32 CALC + FIX + DONE cycles, busy for 34 cycles, done_o in the last.
// No backpressure: the core stalls on busy_o and start_i is only honoured in IDLE.
module mul_seq
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  mul_state_e        r_state;
  mul_op_e           r_op;
  logic              r_neg;
  logic [2*XLEN-1:0] r_mcand;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_mplier;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_result;
  logic              r_busy;
  logic              r_done;

  mul_op_e           w_op;
  logic              w_sign_a;
  logic              w_sign_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [2*XLEN-1:0] w_fixed;

  assign w_op     = mul_op_e'(op_i);
  assign w_sign_a = a_i[XLEN-1] & ((w_op == MULH) | (w_op == MULHSU));
  assign w_sign_b = b_i[XLEN-1] & (w_op == MULH);
  // Negating 0x80000000 yields 0x80000000, which read unsigned is the correct magnitude 2^31.
  assign w_mag_a  = w_sign_a ? -a_i : a_i;
  assign w_mag_b  = w_sign_b ? -b_i : b_i;
  assign w_fixed  = r_neg ? -r_prod : r_prod;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_op     <= MUL;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_op     <= w_op;
            r_neg    <= w_sign_a ^ w_sign_b;
            r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          if (r_mplier[0]) begin
            r_prod <= r_prod + r_mcand;
          end
          r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(MUL_ITER - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_result <= (r_op == MUL) ? w_fixed[XLEN-1:0] : w_fixed[2*XLEN-1:XLEN];
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule
